// File: rtl/modular_exp_pkg.sv
// Shared definitions for the modular exponentiation block: FSM state encoding
// and the default operand width.
package modular_exp_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    REDUCE = 3'd1,
    CHECK  = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/modular_mult.sv
// Interleaved shift-add modular multiplier, MSB-first, one bit of b per cycle.
// Requires a < n on start; p = a*b mod n is valid in the cycle ready pulses.
module modular_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             ready
);

  localparam int PW    = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH);

  logic [PW-1:0]    a_q;
  logic [PW-1:0]    n_q;
  logic [PW-1:0]    acc_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    sub1;
  logic [PW-1:0]    step;

  // acc < n and a < n keep 2*acc + a below 3n, so two subtractions suffice.
  always_comb begin
    sum  = {acc_q[PW-2:0], 1'b0} + (b_q[WIDTH-1] ? a_q : '0);
    sub1 = (sum >= n_q) ? sum - n_q : sum;
    step = (sub1 >= n_q) ? sub1 - n_q : sub1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start && !busy_q) begin
        a_q    <= {2'b00, a};
        n_q    <= {2'b00, n};
        b_q    <= b;
        acc_q  <= '0;
        cnt_q  <= CNT_W'(WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= step;
        b_q   <= {b_q[WIDTH-2:0], 1'b0};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          ready  <= 1'b1;
        end
      end
    end
  end

  assign p = acc_q[WIDTH-1:0];

endmodule

// File: rtl/modular_exp.sv
// Right-to-left binary modular exponentiation: result = M^D mod N.
// Starts on the first clock edge after reset release; done is sticky.
module modular_exp
  import modular_exp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  state_t           state, next_state;
  logic [WIDTH-1:0] m_q, d_q, n_q, acc_q, base_q, result_q;
  logic             done_q;
  logic             issued_q;
  logic             mul_start, sq_start;
  logic             mul_ready, sq_ready;
  logic [WIDTH-1:0] mul_a, mul_b, mul_p, sq_p;
  logic             n_trivial;

  assign n_trivial = (N[WIDTH-1:1] == '0);

  // REDUCE computes 1*M so the multiplier's a-operand is already below N.
  assign mul_a = (state == REDUCE) ? WIDTH'(1) : acc_q;
  assign mul_b = (state == REDUCE) ? m_q : base_q;

  modular_mult #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset(reset), .start(mul_start),
    .a(mul_a), .b(mul_b), .n(n_q), .p(mul_p), .ready(mul_ready)
  );

  modular_mult #(.WIDTH(WIDTH)) u_sq (
    .clk(clk), .reset(reset), .start(sq_start),
    .a(base_q), .b(base_q), .n(n_q), .p(sq_p), .ready(sq_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    sq_start   = 1'b0;
    case (state)
      LOAD:   next_state = n_trivial ? DONE : REDUCE;
      REDUCE: begin
        mul_start = !issued_q;
        if (mul_ready) next_state = CHECK;
      end
      CHECK:  next_state = (d_q == '0) ? DONE : MULT;
      MULT:   begin
        mul_start = !issued_q;
        sq_start  = !issued_q;
        if (mul_ready && sq_ready) next_state = CHECK;
      end
      DONE:   next_state = DONE;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q      <= '0;
      d_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          m_q   <= M;
          d_q   <= D;
          n_q   <= N;
          acc_q <= WIDTH'(1);
          if (n_trivial) done_q <= 1'b1;
        end
        REDUCE: begin
          if (mul_start) issued_q <= 1'b1;
          if (mul_ready) begin
            base_q   <= mul_p;
            issued_q <= 1'b0;
          end
        end
        CHECK: begin
          if (d_q == '0) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
          end
        end
        MULT: begin
          if (mul_start) issued_q <= 1'b1;
          if (mul_ready && sq_ready) begin
            if (d_q[0]) acc_q <= mul_p;
            base_q   <= sq_p;
            d_q      <= d_q >> 1;
            issued_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_modular_exp.sv
// Directed bench for modular_exp: table of {M, D, N, expected} vectors plus
// hand-written sequences for abort-and-restart and post-load input changes.
module tb_modular_exp;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] M = '0;
  logic [W-1:0] D = '0;
  logic [W-1:0] N = '0;
  logic [W-1:0] result;
  logic         done;

  int total  = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] d;
    logic [W-1:0] n;
    logic [W-1:0] exp_res;
    int           max_cyc;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  modular_exp #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .M(M), .D(D), .N(N),
    .result(result), .done(done)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Latency bound (W+3)*(k+1)+4 where k is the bit length of d.
  function automatic int lat_bound(input logic [W-1:0] d);
    int k = 0;
    for (int i = 0; i < W; i++) if (d[i]) k = i + 1;
    return (W + 3) * (k + 1) + 4;
  endfunction

  task automatic hold_reset(input string name, input int cycles);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({name, "_rst_result"}, result, '0);
    check({name, "_rst_done"}, {{(W-1){1'b0}}, done}, '0);
    repeat (cycles) @(negedge clk);
    check({name, "_held_result"}, result, '0);
    check({name, "_held_done"}, {{(W-1){1'b0}}, done}, '0);
  endtask

  // Releases reset with the given operands, scrambles the inputs right after
  // the load edge, then waits for done and scores result and latency.
  task automatic run_vec(input string name, input vec_t v);
    int   cyc;
    logic leak;
    hold_reset(name, 3);
    M = v.m;
    D = v.d;
    N = v.n;
    exp_q.push_back(v.exp_res);
    reset = 1'b1;
    cyc  = 0;
    leak = 1'b0;
    while (!done && cyc < v.max_cyc + 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        M = v.m ^ 32'hA5A5_5A5A;
        D = v.d + 32'd3;
        N = v.n + 32'd2;
      end
      if (!done && result !== '0) leak = 1'b1;
    end
    check({name, "_done"}, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, 1'b1});
    check({name, "_result"}, result, exp_q.pop_front());
    check({name, "_zero_before_done"}, {{(W-1){1'b0}}, leak}, '0);
    total++;
    if (cyc <= v.max_cyc) passed++;
    else $display("FAIL %s_latency: took %0d cycles limit %0d", name, cyc, v.max_cyc);
    repeat (10) @(negedge clk);
    check({name, "_sticky_done"}, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, 1'b1});
    check({name, "_sticky_result"}, result, v.exp_res);
  endtask

  initial begin
    vecs[0]  = '{m: 32'd6,          d: 32'd3,          n: 32'd9,          exp_res: 32'd0,  max_cyc: 0};
    vecs[1]  = '{m: 32'd8,          d: 32'd7,          n: 32'd13,         exp_res: 32'd5,  max_cyc: 0};
    vecs[2]  = '{m: 32'd63,         d: 32'd3,          n: 32'd17,         exp_res: 32'd11, max_cyc: 0};
    vecs[3]  = '{m: 32'd89,         d: 32'd5,          n: 32'd19,         exp_res: 32'd14, max_cyc: 0};
    vecs[4]  = '{m: 32'd5,          d: 32'd0,          n: 32'd7,          exp_res: 32'd1,  max_cyc: 0};
    vecs[5]  = '{m: 32'd5,          d: 32'd4,          n: 32'd1,          exp_res: 32'd0,  max_cyc: 3};
    vecs[6]  = '{m: 32'hFFFF_FFFF,  d: 32'd2,          n: 32'hFFFF_FFFB,  exp_res: 32'd16, max_cyc: 0};
    vecs[7]  = '{m: 32'd0,          d: 32'd5,          n: 32'd7,          exp_res: 32'd0,  max_cyc: 0};
    vecs[8]  = '{m: 32'd5,          d: 32'd3,          n: 32'd0,          exp_res: 32'd0,  max_cyc: 3};
    vecs[9]  = '{m: 32'd2,          d: 32'd10,         n: 32'd1000,       exp_res: 32'd24, max_cyc: 0};
    vecs[10] = '{m: 32'd3,          d: 32'hFFFF_FFFF,  n: 32'd7,          exp_res: 32'd6,  max_cyc: 0};
    for (int i = 0; i < 11; i++)
      if (vecs[i].max_cyc == 0) vecs[i].max_cyc = lat_bound(vecs[i].d);
    vecs[0].max_cyc = (vecs[0].max_cyc < 150) ? vecs[0].max_cyc : 150;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset after a finished computation must clear the outputs.
    hold_reset("post_done", 20);

    // Abort 8^7 mod 13 partway, then restart with 89^5 mod 19.
    M = 32'd8;
    D = 32'd7;
    N = 32'd13;
    reset = 1'b1;
    repeat (60) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_result", result, '0);
    check("abort_done", {{(W-1){1'b0}}, done}, '0);
    repeat (20) @(negedge clk);
    begin
      vec_t v;
      v = '{m: 32'd89, d: 32'd5, n: 32'd19, exp_res: 32'd14, max_cyc: lat_bound(32'd5)};
      run_vec("restart", v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/modular_exp.md
MODULAR_EXP -- requirements
Module: modular_exp

Interface
REQ-001 Parameter WIDTH, default 32, operand/result bit width (WIDTH >= 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low = clear and hold, release = start one computation.
REQ-004 M  input  WIDTH  message/base, unsigned, any value (M >= N allowed).
REQ-005 D  input  WIDTH  exponent, unsigned.
REQ-006 N  input  WIDTH  modulus, unsigned.
REQ-007 result  output  WIDTH  M^D mod N; valid while done=1.
REQ-008 done  output  1  high when result is valid; sticky until next reset.

Function
REQ-009 Computes result = (M^D) mod N exactly, full-precision unsigned arithmetic, no truncation for any WIDTH-bit inputs.
REQ-010 No start pin; the first rising clk edge with reset deasserted latches M, D, N into internal registers. Input changes after that edge are ignored until the next reset.
REQ-011 FSM states: LOAD, REDUCE, CHECK, MULT, DONE; reset enters LOAD.
REQ-012 LOAD: latch operands; acc = 1; go to REDUCE, or to DONE with result 0 if N==0 or N==1.
REQ-013 REDUCE: base = M mod N, computed through the modular multiplier as M*1 mod N; then go to CHECK.
REQ-014 CHECK: if the exponent register is 0, go to DONE. Otherwise go to MULT.
REQ-015 Right-to-left binary method. MULT runs two multiplier instances in parallel: acc = acc*base mod N (result used only if the exponent LSB is 1) and base = base*base mod N. On completion, shift the exponent register right by 1 and return to CHECK.
REQ-016 Modular multiplier is interleaved shift-add, MSB-first, one multiplier bit per cycle. Per cycle: P = 2P + b_i*A, then at most two conditional subtractions of N. Internal width WIDTH+2. Latency WIDTH+2 cycles including start/finish handshake.
REQ-017 Multiplier handshake: 1-cycle start pulse with a and b stable; it raises a 1-cycle ready pulse with the product. The FSM waits for ready in REDUCE and MULT.
REQ-018 D==0 with N>1 gives result 1. M==0 with D>0 gives result 0.
REQ-019 Total latency from the first load edge to done <= (WIDTH+3)*(k+1)+4 cycles, where k = bit length of D. For WIDTH=32 and D<8 this is <= 150 cycles.
REQ-020 DONE: result = acc, done = 1; hold indefinitely, no further register activity.
REQ-021 result = 0 and done = 0 in every state other than DONE.

Reset
REQ-022 reset low asynchronously clears all registers: FSM to LOAD, acc, base, exponent, multiplier state, result = 0, done = 0.
REQ-023 reset asserted mid-computation aborts immediately. On release a fresh computation starts with the then-current inputs; no state is retained.

Structure
REQ-024 Shared package modular_exp_pkg holds the FSM state enum (LOAD, REDUCE, CHECK, MULT, DONE) and the default WIDTH constant.
REQ-025 One sub-module, modular_mult (parameter WIDTH; ports clk, reset, start, a, b, n, p, ready), instantiated twice: multiply and square.
REQ-026 Top-level: FSM, operand/exponent registers and output registers only; no combinational % or / operators anywhere.

Verification (WIDTH=32, 10 ns clock, 200-cycle window after each reset release)
REQ-027 M=6, D=3, N=9 -> done=1 with result=0 within 150 cycles.
REQ-028 M=8, D=7, N=13 -> result=5, done=1.
REQ-029 M=63, D=3, N=17 (M>N) -> result=11, done=1.
REQ-030 M=89, D=5, N=19 -> result=14, done=1. Then assert reset for 20 cycles -> result=0, done=0.
REQ-031 Edge cases:
- M=5, D=0, N=7 -> result=1.
- M=5, D=4, N=1 -> result=0, done within 3 cycles.
- M=0xFFFFFFFF, D=2, N=0xFFFFFFFB -> result=16.
REQ-032 Reset asserted midway through M=8, D=7, N=13; released with M=89, D=5, N=19 -> result=14. Changing the inputs after the load edge does not alter the result.
